// File: rtl/tt_sel_driver_pkg.sv
// Shared definitions for the design-select pad driver: default geometry and FSM state encoding.
package tt_sel_driver_pkg;

   localparam int SEL_ADDR_W = 10;
   localparam int SEL_DIV    = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DIS   = 3'd1,
      S_RST   = 3'd2,
      S_REL   = 3'd3,
      S_INC_H = 3'd4,
      S_INC_L = 3'd5,
      S_FIN   = 3'd6
   } sel_state_t;

   // Phase timer must be able to hold DIV itself.
   function automatic int timer_width(input int div);
      return $clog2(div + 1);
   endfunction

endpackage

// File: rtl/tt_sel_driver_if.sv
// Request/status handshake between a sequencing master and the design-select driver.
interface tt_sel_driver_if
   import tt_sel_driver_pkg::*;
#(
   parameter int ADDR_W = SEL_ADDR_W
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ena;
   logic              busy;
   logic              done;

   modport master (
      output req_valid, req_addr, req_ena,
      input  req_ready, busy, done
   );

   modport slave (
      input  req_valid, req_addr, req_ena,
      output req_ready, busy, done
   );
endinterface

// File: rtl/tt_sel_driver_timer.sv
// Phase timer: reloads to DIV-1 on state entry, counts down, flags the last cycle of the phase.
module tt_sel_driver_timer
   import tt_sel_driver_pkg::*;
#(
   parameter int DIV = SEL_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);
   localparam int            TW       = timer_width(DIV);
   localparam logic [TW-1:0] LOAD_VAL = TW'(DIV - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);
endmodule

// File: rtl/tt_sel_driver.sv
// Design-select initiator: disable, reset selector, pulse inc A times, then optionally re-enable.
//
//  state | meaning
//  IDLE  | ready for a request, pads hold last values
//  DIS   | design disabled, inc low
//  RST   | selector counter held in reset
//  REL   | selector reset released, setup before first inc
//  INC_H | inc pulse high phase
//  INC_L | inc pulse low phase, pulse counted on exit
//  FIN   | one cycle: apply enable, pulse done
module tt_sel_driver
   import tt_sel_driver_pkg::*;
#(
   parameter int ADDR_W = SEL_ADDR_W,
   parameter int DIV    = SEL_DIV
) (
   input  logic            clk,
   input  logic            rst_n,
   tt_sel_driver_if.slave  bus,
   output logic            ctrl_sel_rst_n,
   output logic            ctrl_sel_inc,
   output logic            ctrl_ena
);
   sel_state_t        state;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] pulse_cnt;
   logic              ena_q;
   logic              ready_q;
   logic              done_q;
   logic              accept;
   logic              expired;
   logic              timer_load;
   logic              last_pulse;

   assign accept     = ready_q & bus.req_valid;
   assign timer_load = accept | (expired & (state != S_IDLE) & (state != S_FIN));
   // Compare against A-1 before incrementing so the all-ones address never wraps.
   assign last_pulse = (pulse_cnt == (addr_q - 1'b1));

   tt_sel_driver_timer #(.DIV(DIV)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         addr_q         <= '0;
         pulse_cnt      <= '0;
         ena_q          <= 1'b0;
         ready_q        <= 1'b0;
         done_q         <= 1'b0;
         ctrl_sel_rst_n <= 1'b0;
         ctrl_sel_inc   <= 1'b0;
         ctrl_ena       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  addr_q       <= bus.req_addr;
                  ena_q        <= bus.req_ena;
                  pulse_cnt    <= '0;
                  ctrl_ena     <= 1'b0;
                  ctrl_sel_inc <= 1'b0;
                  ready_q      <= 1'b0;
                  state        <= S_DIS;
               end
            end
            S_DIS: begin
               if (expired) begin
                  ctrl_sel_rst_n <= 1'b0;
                  state          <= S_RST;
               end
            end
            S_RST: begin
               if (expired) begin
                  ctrl_sel_rst_n <= 1'b1;
                  state          <= S_REL;
               end
            end
            S_REL: begin
               if (expired) begin
                  if (addr_q == '0) begin
                     ctrl_ena <= ena_q;
                     done_q   <= 1'b1;
                     state    <= S_FIN;
                  end else begin
                     ctrl_sel_inc <= 1'b1;
                     state        <= S_INC_H;
                  end
               end
            end
            S_INC_H: begin
               if (expired) begin
                  ctrl_sel_inc <= 1'b0;
                  state        <= S_INC_L;
               end
            end
            S_INC_L: begin
               if (expired) begin
                  if (last_pulse) begin
                     ctrl_ena <= ena_q;
                     done_q   <= 1'b1;
                     state    <= S_FIN;
                  end else begin
                     pulse_cnt    <= pulse_cnt + 1'b1;
                     ctrl_sel_inc <= 1'b1;
                     state        <= S_INC_H;
                  end
               end
            end
            S_FIN: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
endmodule

// File: tb/tb_tt_sel_driver.sv
// Bench for tt_sel_driver: table vectors, random requests and hand-written corner sequences.
module tb_tt_sel_driver;
   localparam int ADDR_W = 10;
   localparam int DIV    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sel_rst_n;
   logic sel_inc;
   logic ena;

   tt_sel_driver_if #(.ADDR_W(ADDR_W)) bus ();

   tt_sel_driver #(.ADDR_W(ADDR_W), .DIV(DIV)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .ctrl_sel_rst_n (sel_rst_n),
      .ctrl_sel_inc   (sel_inc),
      .ctrl_ena       (ena)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_err = 0;

   // Pad-level model of the tt_ctrl selector plus protocol invariants.
   int   model_sel = 0;
   int   edges     = 0;
   int   rst_low   = 0;
   int   viol      = 0;
   logic prev_inc  = 1'b0;
   bit   first_req = 1'b1;

   always @(negedge clk) begin
      if (sel_rst_n !== 1'b1) model_sel = 0;
      else if (sel_inc === 1'b1 && prev_inc !== 1'b1) begin
         model_sel++;
         edges++;
      end
      prev_inc = sel_inc;
      if (bus.busy === 1'b1 && sel_rst_n !== 1'b1) rst_low++;
      if (sel_inc === 1'b1 && sel_rst_n !== 1'b1) viol++;
      if (ena === 1'b1 && bus.busy === 1'b1 && bus.done !== 1'b1) viol++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input int a);
      return DIV * (3 + 2 * a);
   endfunction

   task automatic clear_model();
      edges   = 0;
      rst_low = 0;
      viol    = 0;
   endtask

   task automatic wait_ready(input string name, output bit ok);
      int t = 0;
      while (bus.req_ready !== 1'b1 && t < 50) begin
         @(negedge clk); #1;
         t++;
      end
      ok = (t < 50);
      if (!ok) check({name, " accept timeout"}, 0, 1);
   endtask

   task automatic wait_done(input string name, output bit ok);
      int t = 0;
      while (bus.done !== 1'b1 && t < 20000) begin
         @(negedge clk); #1;
         t++;
      end
      ok = (t < 20000);
      if (!ok) check({name, " done timeout"}, 0, 1);
   endtask

   task automatic run_req(input int a, input bit e, input int lat_exp, input string name);
      bit ok;
      int acc;
      @(negedge clk); #1;
      clear_model();
      bus.req_addr  = ADDR_W'(a);
      bus.req_ena   = e;
      bus.req_valid = 1'b1;
      wait_ready(name, ok);
      if (!ok) begin
         bus.req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      @(negedge clk); #1;
      bus.req_valid = 1'b0;
      check({name, " busy"}, 32'(bus.busy), 1);
      wait_done(name, ok);
      if (!ok) return;
      check({name, " latency"}, cyc - acc, lat_exp);
      check({name, " inc edges"}, edges, a);
      check({name, " selected"}, model_sel, a);
      check({name, " ena"}, 32'(ena), 32'(e));
      check({name, " violations"}, viol, 0);
      check({name, " rst low cycles"}, rst_low, first_req ? 2 * DIV : DIV);
      first_req = 1'b0;
      @(negedge clk); #1;
      check({name, " idle done/busy/ready"}, {29'b0, bus.done, bus.busy, bus.req_ready}, 3'b001);
   endtask

   typedef struct {
      int    addr;
      bit    ena;
      int    lat;
      string name;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int acc;
      int done_edge;

      tbl[0] = '{3,    1'b1, 18,   "T1 A=3"};
      tbl[1] = '{0,    1'b1, 6,    "T2 A=0"};
      tbl[2] = '{4,    1'b0, 22,   "T6 A=4 ena0"};
      tbl[3] = '{1,    1'b1, 10,   "A=1"};
      tbl[4] = '{1023, 1'b1, 4098, "T3 A=1023"};
      tbl[5] = '{7,    1'b0, 34,   "A=7 ena0"};

      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_ena   = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("reset outputs", {26'b0, sel_rst_n, sel_inc, ena, bus.busy, bus.done, bus.req_ready}, 0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("ready after reset", 32'(bus.req_ready), 1);
      check("sel rst held after reset", 32'(sel_rst_n), 0);

      for (int i = 0; i < 6; i++) run_req(tbl[i].addr, tbl[i].ena, tbl[i].lat, tbl[i].name);

      for (int i = 0; i < 20; i++) begin
         int a;
         bit e;
         a = $urandom_range(0, 40);
         e = 1'($urandom_range(0, 1));
         run_req(a, e, exp_latency(a), "random");
      end

      // T4: request held across busy with a different address.
      @(negedge clk); #1;
      clear_model();
      bus.req_addr  = 10'd5;
      bus.req_ena   = 1'b1;
      bus.req_valid = 1'b1;
      wait_ready("T4 first", ok);
      if (ok) begin
         int ready_seen;
         int t;
         ready_seen = 0;
         t = 0;
         acc = cyc + 1;
         @(negedge clk); #1;
         bus.req_addr = 10'd9;
         while (bus.done !== 1'b1 && t < 20000) begin
            if (bus.req_ready === 1'b1) ready_seen++;
            @(negedge clk); #1;
            t++;
         end
         check("T4 first latency", cyc - acc, exp_latency(5));
         check("T4 ready while busy", ready_seen, 0);
         check("T4 first selected", model_sel, 5);
         done_edge = cyc;
         @(negedge clk); #1;
         check("T4 ready after done", 32'(bus.req_ready), 1);
         clear_model();
         @(negedge clk); #1;
         bus.req_valid = 1'b0;
         check("T4 second busy", 32'(bus.busy), 1);
         wait_done("T4 second", ok);
         if (ok) begin
            check("T4 second latency", cyc - (done_edge + 2), exp_latency(9));
            check("T4 second selected", model_sel, 9);
         end
         @(negedge clk); #1;
      end
      bus.req_valid = 1'b0;

      // T5: asynchronous reset during the high phase of pulse 5 of A=9.
      @(negedge clk); #1;
      clear_model();
      bus.req_addr  = 10'd9;
      bus.req_ena   = 1'b1;
      bus.req_valid = 1'b1;
      wait_ready("T5", ok);
      @(negedge clk); #1;
      bus.req_valid = 1'b0;
      if (ok) begin
         int t;
         t = 0;
         while (!(edges == 5 && sel_inc === 1'b1) && t < 200) begin
            @(negedge clk); #1;
            t++;
         end
         check("T5 reached pulse 5", 32'(t < 200), 1);
         rst_n = 1'b0;
         #1;
         check("T5 outputs in reset", {26'b0, sel_rst_n, sel_inc, ena, bus.busy, bus.done, bus.req_ready}, 0);
         @(negedge clk);
         @(negedge clk); #1;
         rst_n     = 1'b1;
         first_req = 1'b1;
         run_req(2, 1'b1, 14, "T5 after reset");
      end
      rst_n = 1'b1;

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
